row_clearer: RTL and testbench
==============================

Name: row_clearer

Overview:
- Consumer side of the full-row scanner handshake.
- The scanner presents a row index and an `enabled` (row complete) flag. This block captures a complete row, holds the scanner paused, and flashes the row for display.
- It then collapses the board one row per clock and hands the updated board back to the game top with a one-cycle write strobe.
- Multiple complete rows are cleared one at a time, as the scanner finds each in turn.

Parameters:
BLOCKS_WIDE, 10, cells per row (matches `BLOCKS_WIDE)
BLOCKS_HIGH, 22, rows on board (matches `BLOCKS_HIGH); row 0 is the top row
BITS_Y_POS, 5, width of a row index (matches `BITS_Y_POS)
FLASH_CYCLES, 4, clocks the target row is flashed before collapse; must be >= 1
CNT_W, 16, width of cleared-lines counter

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
game_pause  in  1  when high, no new clear is accepted from IDLE; an in-progress clear continues
fallen_pieces  in  BLOCKS_WIDE*BLOCKS_HIGH  current board; row r is bits [r*BLOCKS_WIDE +: BLOCKS_WIDE]
row  in  BITS_Y_POS  row index from scanner
enabled  in  1  scanner flag: `row` is complete
scan_pause  out  1  drives scanner pause; high whenever state != IDLE
flash_active  out  1  high in FLASH state
flash_row  out  BITS_Y_POS  captured target row; valid while flash_active
board_out  out  BLOCKS_WIDE*BLOCKS_HIGH  collapsed board; valid when board_we
board_we  out  1  one-cycle strobe; game top loads board_out into fallen_pieces on this edge
lines_cleared  out  CNT_W  total rows cleared since reset; saturates at all-ones

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - scan_pause=0, flash_active=0, board_we=0, flash_row=0, board_out=0, lines_cleared=0.
  - Internal board copy and counters are cleared.
  - A reset mid-clear abandons the clear; no board_we is issued.
- All outputs are registered.
- Row bounds:
  - Row wrap of the target index is not possible.
  - An enabled row with index >= BLOCKS_HIGH is ignored and the block stays IDLE.
- IDLE:
  - Accepts a clear when enabled=1, game_pause=0 and row < BLOCKS_HIGH.
  - On that edge: capture fallen_pieces into the internal board, capture row into the target and flash_row, load flash counter = FLASH_CYCLES-1, and go to FLASH.
  - scan_pause rises on the same edge, so the scanner's next increment is its last until release.
- FLASH:
  - flash_active=1.
  - Counter decrements each clock; at 0, load cur=target and go to SHIFT.
  - Occupies exactly FLASH_CYCLES clocks.
  - enabled and row inputs are ignored.
- SHIFT, one row per clock:
  - If cur != 0: board[cur] <= board[cur-1], cur <= cur-1.
  - If cur == 0: board[0] <= all zeros, go to COMMIT.
  - Occupies target+1 clocks; target=0 takes 1 clock and clears only row 0.
  - Rows below target are never modified.
- COMMIT (1 clock):
  - board_we=1, board_out=internal board.
  - lines_cleared increments by 1; it holds if already all-ones.
  - Next state is SETTLE.
- SETTLE (1 clock):
  - scan_pause stays high and enabled is ignored, so the scanner's stale flag from the pre-writeback board cannot retrigger.
  - Next state is IDLE; scan_pause falls on that edge.
- Latency: board_we is high in the single cycle after the (FLASH_CYCLES+target+2)th edge following the capture edge. scan_pause is high for FLASH_CYCLES+target+3 cycles in total.
- Inputs while busy: fallen_pieces changes outside IDLE are ignored, because the game top must not write the board while scan_pause=1. Only the captured copy is used.
- game_pause:
  - Rising in FLASH, SHIFT, COMMIT or SETTLE has no effect; the clear completes.
  - It gates only acceptance in IDLE.
- board_we is never high in two consecutive cycles.

Test Plan:
1. Reset then idle: rst=1 for 2 clocks, enabled=0 -> every output 0, state IDLE, no board_we for 50 clocks.
2. Single clear, target row 21, rows 20 and 21 full, all other rows empty:
   - Stimulus: enabled=1, row=21.
   - Required: flash_active high for 4 clocks with flash_row=21; board_we exactly 4+21+2=27 clocks after the capture edge.
   - board_out: row 21 full (old row 20), rows 0..20 zero.
   - lines_cleared=1; scan_pause high for 28 cycles.
3. Top row, target 0, row 0 full, row 5 = 10'b0000000001:
   - Required: SHIFT lasts 1 clock; board_we at capture+6.
   - board_out: row 0 zero, row 5 unchanged.
4. Ignore paths:
   - enabled=1 with row=25 -> no capture.
   - enabled=1 with game_pause=1 -> no capture.
   - enabled toggled every clock during FLASH and SHIFT of a row-10 clear -> exactly one board_we, lines_cleared=1.
5. Reset mid-clear: assert rst at capture+10 of a row-15 clear -> state IDLE next clock, no board_we ever, lines_cleared=0, scan_pause=0.
6. Back-to-back clears: rows 18 and 19 full; scanner model re-asserts on the updated board -> two board_we pulses separated by >= 2 idle cycles, final lines_cleared=2, rows 18 and 19 cleared with upper content shifted down by 2.

Source files
------------

// File: rtl/row_clearer.sv
// Full-row clear engine: captures a complete row reported by the scanner, flashes it,
// collapses the board above it one row per clock and writes the result back to the game top.
module row_clearer #(
  parameter int BLOCKS_WIDE  = 10,
  parameter int BLOCKS_HIGH  = 22,
  parameter int BITS_Y_POS   = 5,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_game_pause,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] i_fallen_pieces,
  input  logic [BITS_Y_POS-1:0]              i_row,
  input  logic                               i_enabled,
  output logic                               o_scan_pause,
  output logic                               o_flash_active,
  output logic [BITS_Y_POS-1:0]              o_flash_row,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] o_board_out,
  output logic                               o_board_we,
  output logic [CNT_W-1:0]                   o_lines_cleared
);

  localparam int BW  = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int FCW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [BITS_Y_POS:0] ROW_LIMIT  = (BITS_Y_POS+1)'(BLOCKS_HIGH);
  localparam logic [FCW-1:0]      FLASH_LOAD = FCW'(FLASH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLASH  = 3'd1,
    S_SHIFT  = 3'd2,
    S_COMMIT = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BW-1:0]         r_board;
  logic [BW-1:0]         w_board_nxt;
  logic [BW-1:0]         r_board_out;
  logic [BW-1:0]         w_board_out_nxt;
  logic [BITS_Y_POS-1:0] r_flash_row;
  logic [BITS_Y_POS-1:0] w_flash_row_nxt;
  logic [BITS_Y_POS-1:0] r_cur;
  logic [BITS_Y_POS-1:0] w_cur_nxt;
  logic [FCW-1:0]        r_flash_cnt;
  logic [FCW-1:0]        w_flash_cnt_nxt;
  logic [CNT_W-1:0]      r_lines;
  logic [CNT_W-1:0]      w_lines_nxt;
  logic                  r_board_we;
  logic                  w_board_we_nxt;
  logic                  r_scan_pause;
  logic                  r_flash_active;
  logic                  w_accept;

  // Out-of-range rows are dropped here so the target index can never wrap.
  assign w_accept = i_enabled & ~i_game_pause & ({1'b0, i_row} < ROW_LIMIT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, board collapse and write-back decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_board_nxt     = r_board;
    w_board_out_nxt = r_board_out;
    w_flash_row_nxt = r_flash_row;
    w_cur_nxt       = r_cur;
    w_flash_cnt_nxt = r_flash_cnt;
    w_lines_nxt     = r_lines;
    w_board_we_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = S_FLASH;
          w_board_nxt     = i_fallen_pieces;
          w_flash_row_nxt = i_row;
          w_flash_cnt_nxt = FLASH_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FLASH: begin
        if (r_flash_cnt == {FCW{1'b0}}) begin
          w_cur_nxt   = r_flash_row;
          w_state_nxt = S_SHIFT;
        end else begin
          w_flash_cnt_nxt = r_flash_cnt - FCW'(1);
        end
      end
      S_SHIFT: begin
        if (r_cur != {BITS_Y_POS{1'b0}}) begin
          for (int r = 1; r < BLOCKS_HIGH; r++) begin
            w_board_nxt[r*BLOCKS_WIDE +: BLOCKS_WIDE] = (r_cur == BITS_Y_POS'(r)) ?
                r_board[(r-1)*BLOCKS_WIDE +: BLOCKS_WIDE] :
                r_board[r*BLOCKS_WIDE +: BLOCKS_WIDE];
          end
          w_cur_nxt = r_cur - BITS_Y_POS'(1);
        end else begin
          w_board_nxt[BLOCKS_WIDE-1:0] = {BLOCKS_WIDE{1'b0}};
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_board_we_nxt  = 1'b1;
        w_board_out_nxt = r_board;
        w_lines_nxt     = (r_lines == {CNT_W{1'b1}}) ? r_lines : r_lines + CNT_W'(1);
        w_state_nxt     = S_SETTLE;
      end
      // One extra paused cycle so the scanner's flag from the old board is not re-taken.
      S_SETTLE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_board        <= {BW{1'b0}};
      r_board_out    <= {BW{1'b0}};
      r_flash_row    <= {BITS_Y_POS{1'b0}};
      r_cur          <= {BITS_Y_POS{1'b0}};
      r_flash_cnt    <= {FCW{1'b0}};
      r_lines        <= {CNT_W{1'b0}};
      r_board_we     <= 1'b0;
      r_scan_pause   <= 1'b0;
      r_flash_active <= 1'b0;
    end else begin
      r_board        <= w_board_nxt;
      r_board_out    <= w_board_out_nxt;
      r_flash_row    <= w_flash_row_nxt;
      r_cur          <= w_cur_nxt;
      r_flash_cnt    <= w_flash_cnt_nxt;
      r_lines        <= w_lines_nxt;
      r_board_we     <= w_board_we_nxt;
      r_scan_pause   <= (w_state_nxt != S_IDLE);
      r_flash_active <= (w_state_nxt == S_FLASH);
    end
  end

  assign o_scan_pause    = r_scan_pause;
  assign o_flash_active  = r_flash_active;
  assign o_flash_row     = r_flash_row;
  assign o_board_out     = r_board_out;
  assign o_board_we      = r_board_we;
  assign o_lines_cleared = r_lines;

  row_clearer_chk u_chk (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_scan_pause   (r_scan_pause),
    .i_flash_active (r_flash_active),
    .i_board_we     (r_board_we)
  );

endmodule

// Protocol properties of the clear handshake outputs.
module row_clearer_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_scan_pause,
  input logic i_flash_active,
  input logic i_board_we
);

  a_we_single: assert property (@(posedge i_clk) disable iff (i_rst) i_board_we |=> !i_board_we);
  a_flash_paused: assert property (@(posedge i_clk) disable iff (i_rst) i_flash_active |-> i_scan_pause);
  a_we_paused: assert property (@(posedge i_clk) disable iff (i_rst) i_board_we |-> i_scan_pause);

endmodule

// File: tb/tb_row_clearer.sv
// Self-checking bench for row_clearer: directed vector table, reset and back-to-back
// sequences, then randomized clears checked against a queue-based board model.
module tb_row_clearer;

  localparam int W  = 10;
  localparam int H  = 22;
  localparam int YB = 5;
  localparam int FC = 4;
  localparam int CW = 16;
  localparam int BW = W * H;

  logic          clk;
  logic          rst;
  logic          game_pause;
  logic          enabled;
  logic [BW-1:0] fallen;
  logic [YB-1:0] row;
  logic          o_scan_pause;
  logic          o_flash_active;
  logic [YB-1:0] o_flash_row;
  logic [BW-1:0] o_board_out;
  logic          o_board_we;
  logic [CW-1:0] o_lines_cleared;

  int n_vec = 0;
  int n_bad = 0;
  int exp_lines = 0;

  typedef struct {
    logic [BW-1:0] board;
    logic [YB-1:0] row;
    logic          gp;
    logic          accept;
    logic          noise;
    logic [BW-1:0] exp_board;
  } vec_t;

  row_clearer #(
    .BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .BITS_Y_POS(YB), .FLASH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_game_pause    (game_pause),
    .i_fallen_pieces (fallen),
    .i_row           (row),
    .i_enabled       (enabled),
    .o_scan_pause    (o_scan_pause),
    .o_flash_active  (o_flash_active),
    .o_flash_row     (o_flash_row),
    .o_board_out     (o_board_out),
    .o_board_we      (o_board_we),
    .o_lines_cleared (o_lines_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] put_row(input logic [BW-1:0] b, input int r, input logic [W-1:0] v);
    b[r*W +: W] = v;
    return b;
  endfunction

  // Clearing a row = removing it from the stack of rows and dropping an empty row on top.
  function automatic logic [BW-1:0] clear_ref(input logic [BW-1:0] b, input int t);
    logic [W-1:0]  q[$];
    logic [BW-1:0] res;
    for (int r = 0; r < H; r++) q.push_back(b[r*W +: W]);
    q.delete(t);
    q.push_front({W{1'b0}});
    for (int r = 0; r < H; r++) res[r*W +: W] = q[r];
    return res;
  endfunction

  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] b;
    for (int r = 0; r < H; r++) b[r*W +: W] = W'($urandom);
    return b;
  endfunction

  function automatic vec_t mk(input logic [BW-1:0] b, input int r, input logic gp,
                              input logic acc, input logic nz, input logic [BW-1:0] e);
    vec_t v;
    v.board = b; v.row = YB'(r); v.gp = gp; v.accept = acc; v.noise = nz; v.exp_board = e;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one request at a negedge and follow the whole clear cycle by cycle.
  task automatic apply(input vec_t v, input string nm);
    int last;
    fallen = v.board; row = v.row; enabled = 1'b1; game_pause = v.gp;
    if (!v.accept) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); @(negedge clk);
        chk1({nm, " reject scan_pause"}, o_scan_pause, 1'b0);
        chk1({nm, " reject board_we"}, o_board_we, 1'b0);
        chki({nm, " reject lines"}, int'(o_lines_cleared), exp_lines);
      end
      enabled = 1'b0; game_pause = 1'b0;
    end else begin
      last = FC + int'(v.row) + 2;
      @(posedge clk);
      for (int n = 0; n <= last + 2; n++) begin
        @(negedge clk);
        chk1({nm, " scan_pause"}, o_scan_pause, n <= last);
        chk1({nm, " flash_active"}, o_flash_active, n < FC);
        chk1({nm, " board_we"}, o_board_we, n == last);
        if (n < FC) chki({nm, " flash_row"}, int'(o_flash_row), int'(v.row));
        if (n == last) begin
          chkb({nm, " board_out"}, o_board_out, v.exp_board);
          exp_lines++;
        end
        chki({nm, " lines"}, int'(o_lines_cleared), exp_lines);
        if (v.noise && n <= last) begin
          enabled = ~enabled; row = YB'($urandom); game_pause = 1'($urandom); fallen = rand_board();
        end else begin
          enabled = 1'b0; game_pause = 1'b0;
        end
      end
    end
  endtask

  vec_t          tab[6];
  vec_t          v;
  logic [BW-1:0] b6, exp6, final_b;
  int            pulses, t1, t2, found, mode;

  initial begin
    tab[0] = mk(put_row(put_row('0, 20, 10'h3FF), 21, 10'h3FF), 21, 1'b0, 1'b1, 1'b0,
                put_row('0, 21, 10'h3FF));
    tab[1] = mk(put_row(put_row('0, 0, 10'h3FF), 5, 10'h001), 0, 1'b0, 1'b1, 1'b0,
                put_row('0, 5, 10'h001));
    tab[2] = mk(put_row('0, 7, 10'h3FF), 25, 1'b0, 1'b0, 1'b0, '0);
    tab[3] = mk(put_row('0, 7, 10'h3FF), 22, 1'b0, 1'b0, 1'b0, '0);
    tab[4] = mk(put_row('0, 7, 10'h3FF), 7, 1'b1, 1'b0, 1'b0, '0);
    tab[5] = mk(put_row(put_row('0, 10, 10'h3FF), 3, 10'h155), 10, 1'b0, 1'b1, 1'b1,
                put_row('0, 4, 10'h155));

    // Reset then idle
    rst = 1'b1; enabled = 1'b0; game_pause = 1'b0; fallen = '0; row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst scan_pause", o_scan_pause, 1'b0);
    chk1("rst flash_active", o_flash_active, 1'b0);
    chk1("rst board_we", o_board_we, 1'b0);
    chki("rst flash_row", int'(o_flash_row), 0);
    chkb("rst board_out", o_board_out, '0);
    chki("rst lines", int'(o_lines_cleared), 0);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      fallen = rand_board();
      @(negedge clk);
      chk1("idle board_we", o_board_we, 1'b0);
      chk1("idle scan_pause", o_scan_pause, 1'b0);
    end

    // Directed table
    for (int i = 0; i < 6; i++) apply(tab[i], $sformatf("tab%0d", i));

    // Reset in the middle of a row-15 clear
    fallen = rand_board(); row = 5'd15; enabled = 1'b1; game_pause = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      enabled = 1'b0;
      if (n == 9) rst = 1'b1;
    end
    @(negedge clk);
    exp_lines = 0;
    chk1("midrst scan_pause", o_scan_pause, 1'b0);
    chk1("midrst flash_active", o_flash_active, 1'b0);
    chk1("midrst board_we", o_board_we, 1'b0);
    chki("midrst lines", int'(o_lines_cleared), 0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk1("midrst no board_we", o_board_we, 1'b0);
      chk1("midrst idle", o_scan_pause, 1'b0);
    end

    // Back-to-back clears with a scanner/game-top model
    b6 = put_row(put_row(put_row(put_row('0, 18, 10'h3FF), 19, 10'h3FF), 17, 10'h0F0), 10, 10'h001);
    exp6 = clear_ref(clear_ref(b6, 19), 19);
    fallen = b6; pulses = 0; t1 = -1; t2 = -1; final_b = '0;
    for (int c = 0; c < 150; c++) begin
      found = -1;
      for (int r = H - 1; r >= 0; r--) if (found < 0 && fallen[r*W +: W] == {W{1'b1}}) found = r;
      enabled = (found >= 0);
      row = (found >= 0) ? YB'(found) : YB'(0);
      @(posedge clk); @(negedge clk);
      if (o_board_we) begin
        pulses++;
        if (pulses == 1) t1 = c; else t2 = c;
        fallen = o_board_out;
        final_b = o_board_out;
      end
    end
    enabled = 1'b0;
    exp_lines = 2;
    chki("b2b pulses", pulses, 2);
    chk1("b2b gap", (t2 - t1) >= 3, 1'b1);
    chkb("b2b board", final_b, exp6);
    chki("b2b lines", int'(o_lines_cleared), exp_lines);

    // Randomized clears and rejects against the model
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 3);
      v.board = rand_board();
      v.row = YB'($urandom_range(0, H - 1));
      v.gp = 1'b0; v.accept = 1'b1; v.noise = (mode == 1);
      if (mode == 2) begin v.row = YB'($urandom_range(H, 31)); v.accept = 1'b0; end
      if (mode == 3) begin v.gp = 1'b1; v.accept = 1'b0; end
      v.exp_board = v.accept ? clear_ref(v.board, int'(v.row)) : '0;
      apply(v, $sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
